// File: rtl/ysyx_23060236_arbiter_pkg.sv
// Shared encodings for the IFU/LSU AXI arbiter: FSM states and AXI field constants.
package ysyx_23060236_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFU_RD = 2'd1,
    ARB_LSU_RD = 2'd2,
    ARB_LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_23060236_arbiter.sv
// Two-requester AXI4 arbiter (IFU read-only, LSU read/write) in front of the MMU.
// One transaction in flight; responses are steered back by the registered grant state.
module ysyx_23060236_arbiter
  import ysyx_23060236_arbiter_pkg::*;
#(
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_awaddr,
  input  logic [2:0]  lsu_awsize,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  output logic [1:0]  lsu_bresp,
  input  logic        v_io_master_awready,
  output logic        v_io_master_awvalid,
  output logic [31:0] v_io_master_awaddr,
  output logic [3:0]  v_io_master_awid,
  output logic [7:0]  v_io_master_awlen,
  output logic [2:0]  v_io_master_awsize,
  output logic [1:0]  v_io_master_awburst,
  input  logic        v_io_master_wready,
  output logic        v_io_master_wvalid,
  output logic [31:0] v_io_master_wdata,
  output logic [3:0]  v_io_master_wstrb,
  output logic        v_io_master_wlast,
  output logic        v_io_master_bready,
  input  logic        v_io_master_bvalid,
  input  logic [1:0]  v_io_master_bresp,
  input  logic [3:0]  v_io_master_bid,
  input  logic        v_io_master_arready,
  output logic        v_io_master_arvalid,
  output logic [31:0] v_io_master_araddr,
  output logic [3:0]  v_io_master_arid,
  output logic [7:0]  v_io_master_arlen,
  output logic [2:0]  v_io_master_arsize,
  output logic [1:0]  v_io_master_arburst,
  output logic        v_io_master_rready,
  input  logic        v_io_master_rvalid,
  input  logic [1:0]  v_io_master_rresp,
  input  logic [31:0] v_io_master_rdata,
  input  logic        v_io_master_rlast,
  input  logic [3:0]  v_io_master_rid
);

  arb_state_t state_q, state_d;
  logic ar_sent_q, ar_sent_d;
  logic aw_sent_q, aw_sent_d;
  logic w_sent_q, w_sent_d;
  logic last_grant_q, last_grant_d;

  logic ifu_g, lsu_rd_g, lsu_wr_g;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic unused_ok;

  // rid/bid carry no routing information: the grant state alone steers responses.
  assign unused_ok = ^{v_io_master_rid, v_io_master_bid};

  assign ifu_g    = (state_q == ARB_IFU_RD);
  assign lsu_rd_g = (state_q == ARB_LSU_RD);
  assign lsu_wr_g = (state_q == ARB_LSU_WR);

  assign v_io_master_arvalid = ((ifu_g & ifu_arvalid) | (lsu_rd_g & lsu_arvalid)) & ~ar_sent_q;
  assign v_io_master_araddr  = lsu_rd_g ? lsu_araddr : ifu_araddr;
  assign v_io_master_arid    = lsu_rd_g ? LSU_ID : IFU_ID;
  assign v_io_master_arlen   = ifu_g ? ifu_arlen : 8'd0;
  assign v_io_master_arsize  = lsu_rd_g ? lsu_arsize : ifu_arsize;
  assign v_io_master_arburst = BURST_INCR;
  assign ifu_arready = ifu_g & v_io_master_arready & ~ar_sent_q;
  assign lsu_arready = lsu_rd_g & v_io_master_arready & ~ar_sent_q;

  assign ifu_rvalid = ifu_g & v_io_master_rvalid;
  assign ifu_rdata  = v_io_master_rdata;
  assign ifu_rresp  = ifu_g ? v_io_master_rresp : RESP_OKAY;
  assign ifu_rlast  = ifu_g & v_io_master_rlast;
  assign lsu_rvalid = lsu_rd_g & v_io_master_rvalid;
  assign lsu_rdata  = v_io_master_rdata;
  assign lsu_rresp  = lsu_rd_g ? v_io_master_rresp : RESP_OKAY;
  assign v_io_master_rready = (ifu_g & ifu_rready) | (lsu_rd_g & lsu_rready);

  assign v_io_master_awvalid = lsu_wr_g & lsu_awvalid & ~aw_sent_q;
  assign v_io_master_awaddr  = lsu_awaddr;
  assign v_io_master_awid    = LSU_ID;
  assign v_io_master_awlen   = 8'd0;
  assign v_io_master_awsize  = lsu_awsize;
  assign v_io_master_awburst = BURST_INCR;
  assign lsu_awready = lsu_wr_g & v_io_master_awready & ~aw_sent_q;

  assign v_io_master_wvalid = lsu_wr_g & lsu_wvalid & ~w_sent_q;
  assign v_io_master_wdata  = lsu_wdata;
  assign v_io_master_wstrb  = lsu_wstrb;
  assign v_io_master_wlast  = 1'b1;
  assign lsu_wready = lsu_wr_g & v_io_master_wready & ~w_sent_q;

  assign lsu_bvalid = lsu_wr_g & v_io_master_bvalid;
  assign lsu_bresp  = lsu_wr_g ? v_io_master_bresp : RESP_OKAY;
  assign v_io_master_bready = lsu_wr_g & lsu_bready;

  assign ar_hs = v_io_master_arvalid & v_io_master_arready;
  assign aw_hs = v_io_master_awvalid & v_io_master_awready;
  assign w_hs  = v_io_master_wvalid & v_io_master_wready;
  assign r_hs  = v_io_master_rvalid & v_io_master_rready;
  assign b_hs  = v_io_master_bvalid & v_io_master_bready;

  always_comb begin
    state_d      = state_q;
    ar_sent_d    = ar_sent_q;
    aw_sent_d    = aw_sent_q;
    w_sent_d     = w_sent_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (lsu_awvalid) begin
          state_d = ARB_LSU_WR;
        end else if (lsu_arvalid && (!ifu_arvalid || !last_grant_q)) begin
          state_d      = ARB_LSU_RD;
          last_grant_d = 1'b1;
        end else if (ifu_arvalid) begin
          state_d      = ARB_IFU_RD;
          last_grant_d = 1'b0;
        end
      end
      ARB_IFU_RD: begin
        if (ar_hs) ar_sent_d = 1'b1;
        if (r_hs && v_io_master_rlast) begin
          state_d   = ARB_IDLE;
          ar_sent_d = 1'b0;
        end
      end
      // The LSU issues single-beat reads only, so any accepted beat ends it.
      ARB_LSU_RD: begin
        if (ar_hs) ar_sent_d = 1'b1;
        if (r_hs) begin
          state_d   = ARB_IDLE;
          ar_sent_d = 1'b0;
        end
      end
      ARB_LSU_WR: begin
        if (aw_hs) aw_sent_d = 1'b1;
        if (w_hs)  w_sent_d  = 1'b1;
        if (b_hs) begin
          state_d   = ARB_IDLE;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      ar_sent_q    <= 1'b0;
      aw_sent_q    <= 1'b0;
      w_sent_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ar_sent_q    <= ar_sent_d;
      aw_sent_q    <= aw_sent_d;
      w_sent_q     <= w_sent_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; the bench itself plays both requesters and the slave.
module tb_ysyx_23060236_arbiter;

  logic        clock, reset;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_awaddr;
  logic [2:0]  lsu_awsize;
  logic        lsu_wvalid, lsu_wready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid, lsu_bready;
  logic [1:0]  lsu_bresp;
  logic        m_awready, m_awvalid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wready, m_wvalid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bready, m_bvalid;
  logic [1:0]  m_bresp;
  logic [3:0]  m_bid;
  logic        m_arready, m_arvalid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rready, m_rvalid;
  logic [1:0]  m_rresp;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic [3:0]  m_rid;

  int vectors = 0;
  int miscompares = 0;

  ysyx_23060236_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_awsize(lsu_awsize),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .v_io_master_awready(m_awready), .v_io_master_awvalid(m_awvalid),
    .v_io_master_awaddr(m_awaddr), .v_io_master_awid(m_awid), .v_io_master_awlen(m_awlen),
    .v_io_master_awsize(m_awsize), .v_io_master_awburst(m_awburst),
    .v_io_master_wready(m_wready), .v_io_master_wvalid(m_wvalid), .v_io_master_wdata(m_wdata),
    .v_io_master_wstrb(m_wstrb), .v_io_master_wlast(m_wlast),
    .v_io_master_bready(m_bready), .v_io_master_bvalid(m_bvalid), .v_io_master_bresp(m_bresp),
    .v_io_master_bid(m_bid),
    .v_io_master_arready(m_arready), .v_io_master_arvalid(m_arvalid),
    .v_io_master_araddr(m_araddr), .v_io_master_arid(m_arid), .v_io_master_arlen(m_arlen),
    .v_io_master_arsize(m_arsize), .v_io_master_arburst(m_arburst),
    .v_io_master_rready(m_rready), .v_io_master_rvalid(m_rvalid), .v_io_master_rresp(m_rresp),
    .v_io_master_rdata(m_rdata), .v_io_master_rlast(m_rlast), .v_io_master_rid(m_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requesters must hold valid until their address handshake.
  a_ifu_hold: assert property (@(posedge clock) disable iff (reset)
    (ifu_arvalid && !ifu_arready) |=> ifu_arvalid) else $error("ifu_arvalid withdrawn before handshake");
  a_lsu_ar_hold: assert property (@(posedge clock) disable iff (reset)
    (lsu_arvalid && !lsu_arready) |=> lsu_arvalid) else $error("lsu_arvalid withdrawn before handshake");
  a_lsu_aw_hold: assert property (@(posedge clock) disable iff (reset)
    (lsu_awvalid && !lsu_awready) |=> lsu_awvalid) else $error("lsu_awvalid withdrawn before handshake");

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 3'd2; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arsize = 3'd2; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_awsize = 3'd2;
    lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_bready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_rid = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    m_arready = 1; m_rvalid = 1; m_bvalid = 1; m_awready = 1; m_wready = 1;
    ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
    tick();
    vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", m_arvalid); end
    vectors++; if (ifu_arready !== 1'b0 || lsu_arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready: got %b%b want 00", ifu_arready, lsu_arready); end
    vectors++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || lsu_bvalid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b%b%b want 000", ifu_rvalid, lsu_rvalid, lsu_bvalid); end
    vectors++; if (m_rready !== 1'b0 || m_bready !== 1'b0) begin miscompares++; $display("FAIL rst_master_ready: got %b%b want 00", m_rready, m_bready); end
    vectors++; if (lsu_awready !== 1'b0 || lsu_wready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready: got %b%b want 00", lsu_awready, lsu_wready); end
    do_reset();
  endtask

  task automatic test_ifu_burst;
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd3;
    #1;
    vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL burst_arvalid_early: got %b want 0", m_arvalid); end
    tick();
    vectors++; if (m_arvalid !== 1'b1) begin miscompares++; $display("FAIL burst_arvalid: got %b want 1", m_arvalid); end
    vectors++; if (m_arid !== 4'd0 || m_arlen !== 8'd3) begin miscompares++; $display("FAIL burst_arid_len: got %0d/%0d want 0/3", m_arid, m_arlen); end
    vectors++; if (m_araddr !== 32'h3000_0000 || m_arburst !== 2'b01) begin miscompares++; $display("FAIL burst_addr: got %h/%b want 30000000/01", m_araddr, m_arburst); end
    m_arready = 1;
    #1;
    vectors++; if (ifu_arready !== 1'b1) begin miscompares++; $display("FAIL burst_arready: got %b want 1", ifu_arready); end
    tick();
    ifu_arvalid = 0;
    #1;
    vectors++; if (ifu_arready !== 1'b0) begin miscompares++; $display("FAIL burst_arready_after: got %b want 0", ifu_arready); end
    m_arready = 0; ifu_rready = 1;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1; m_rdata = 32'h100 + i; m_rlast = (i == 3);
      #1;
      vectors++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h100 + i || ifu_rlast !== (i == 3)) begin miscompares++; $display("FAIL burst_beat%0d: got v%b d%h l%b", i, ifu_rvalid, ifu_rdata, ifu_rlast); end
      vectors++; if (m_rready !== 1'b1 || lsu_rvalid !== 1'b0) begin miscompares++; $display("FAIL burst_route%0d: got rready %b lsu_rvalid %b want 1/0", i, m_rready, lsu_rvalid); end
      tick();
    end
    m_rlast = 0;
    #1;
    vectors++; if (m_rready !== 1'b0 || ifu_rvalid !== 1'b0) begin miscompares++; $display("FAIL burst_idle: got rready %b rvalid %b want 0/0", m_rready, ifu_rvalid); end
    m_rvalid = 0;
  endtask

  task automatic test_tie;
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0040; ifu_arlen = 8'd1;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0000;
    tick();
    m_arready = 1;
    #1;
    vectors++; if (m_arid !== 4'd0 || ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin miscompares++; $display("FAIL tie1_grant: got id %0d ifu %b lsu %b want 0/1/0", m_arid, ifu_arready, lsu_arready); end
    tick();
    ifu_arvalid = 0; m_arready = 0; ifu_rready = 1; lsu_rready = 1;
    m_rvalid = 1; m_rdata = 32'hAAAA_0000; m_rlast = 0;
    #1;
    vectors++; if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b1) begin miscompares++; $display("FAIL tie1_rroute: got ifu %b lsu %b want 1/0", ifu_rvalid, lsu_rvalid); end
    tick();
    m_rlast = 1;
    tick();
    m_rvalid = 0; m_rlast = 0; m_arready = 1;
    #1;
    vectors++; if (m_arvalid !== 1'b0 || lsu_arready !== 1'b0) begin miscompares++; $display("FAIL tie_bubble: got arvalid %b lsu_arready %b want 0/0", m_arvalid, lsu_arready); end
    tick();
    vectors++; if (m_arvalid !== 1'b1 || m_arid !== 4'd1 || m_arlen !== 8'd0) begin miscompares++; $display("FAIL tie2_grant: got v%b id%0d len%0d want 1/1/0", m_arvalid, m_arid, m_arlen); end
    vectors++; if (m_araddr !== 32'h8000_0000 || lsu_arready !== 1'b1) begin miscompares++; $display("FAIL tie2_addr: got %h ready %b want 80000000/1", m_araddr, lsu_arready); end
    tick();
    lsu_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b10; m_rlast = 1;
    #1;
    vectors++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1234_5678 || lsu_rresp !== 2'b10) begin miscompares++; $display("FAIL tie2_rdata: got v%b %h r%b", lsu_rvalid, lsu_rdata, lsu_rresp); end
    vectors++; if (ifu_rvalid !== 1'b0) begin miscompares++; $display("FAIL tie2_ifu_quiet: got %b want 0", ifu_rvalid); end
    tick();
    m_rvalid = 0; m_rlast = 0; m_rresp = 0;
    ifu_arvalid = 1; lsu_arvalid = 1;
    tick();
    vectors++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0) begin miscompares++; $display("FAIL tie3_grant: got v%b id%0d want 1/0", m_arvalid, m_arid); end
  endtask

  task automatic test_write;
    do_reset();
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010;
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
    tick();
    vectors++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h8000_0010 || m_awlen !== 8'd0 || m_awid !== 4'd1) begin miscompares++; $display("FAIL wr_aw: got v%b %h len%0d id%0d", m_awvalid, m_awaddr, m_awlen, m_awid); end
    vectors++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b0011 || m_wlast !== 1'b1) begin miscompares++; $display("FAIL wr_w: got v%b %h s%b l%b", m_wvalid, m_wdata, m_wstrb, m_wlast); end
    m_wready = 1;
    #1;
    vectors++; if (lsu_wready !== 1'b1 || lsu_awready !== 1'b0) begin miscompares++; $display("FAIL wr_wfirst: got wready %b awready %b want 1/0", lsu_wready, lsu_awready); end
    tick();
    vectors++; if (m_wvalid !== 1'b0 || lsu_wready !== 1'b0 || m_awvalid !== 1'b1) begin miscompares++; $display("FAIL wr_wonce: got wvalid %b wready %b awvalid %b want 0/0/1", m_wvalid, lsu_wready, m_awvalid); end
    tick();
    lsu_wvalid = 0; m_wready = 0; m_awready = 1;
    #1;
    vectors++; if (lsu_awready !== 1'b1) begin miscompares++; $display("FAIL wr_awready: got %b want 1", lsu_awready); end
    tick();
    vectors++; if (m_awvalid !== 1'b0 || lsu_awready !== 1'b0) begin miscompares++; $display("FAIL wr_awonce: got v%b r%b want 0/0", m_awvalid, lsu_awready); end
    lsu_awvalid = 0; m_awready = 0;
    m_bvalid = 1; m_bresp = 2'b00; lsu_bready = 1;
    #1;
    vectors++; if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'b00 || m_bready !== 1'b1) begin miscompares++; $display("FAIL wr_b: got v%b r%b ready%b want 1/00/1", lsu_bvalid, lsu_bresp, m_bready); end
    tick();
    vectors++; if (lsu_bvalid !== 1'b0 || m_bready !== 1'b0) begin miscompares++; $display("FAIL wr_idle: got bvalid %b bready %b want 0/0", lsu_bvalid, m_bready); end
    m_bvalid = 0;
  endtask

  task automatic test_write_vs_read;
    do_reset();
    lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h8000_0020; lsu_wdata = 32'h55;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0100; ifu_arlen = 0;
    tick();
    m_arready = 1;
    #1;
    vectors++; if (m_awvalid !== 1'b1 || m_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin miscompares++; $display("FAIL wvr_prio: got aw %b ar %b ifu_rdy %b want 1/0/0", m_awvalid, m_arvalid, ifu_arready); end
    m_awready = 1; m_wready = 1;
    tick();
    lsu_awvalid = 0; lsu_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; lsu_bready = 1;
    tick();
    m_bvalid = 0;
    #1;
    vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL wvr_bubble: got %b want 0", m_arvalid); end
    tick();
    vectors++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0 || ifu_arready !== 1'b1) begin miscompares++; $display("FAIL wvr_ifu: got v%b id%0d rdy%b want 1/0/1", m_arvalid, m_arid, ifu_arready); end
  endtask

  task automatic test_midburst;
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0200; ifu_arlen = 8'd1;
    tick();
    m_arready = 1;
    tick();
    ifu_arvalid = 0; lsu_arvalid = 1; lsu_araddr = 32'h8000_0100;
    ifu_rready = 1; m_rvalid = 1; m_rlast = 0;
    #1;
    vectors++; if (lsu_arready !== 1'b0) begin miscompares++; $display("FAIL mid_beat0: got %b want 0", lsu_arready); end
    tick();
    m_rlast = 1;
    #1;
    vectors++; if (lsu_arready !== 1'b0) begin miscompares++; $display("FAIL mid_beat1: got %b want 0", lsu_arready); end
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    vectors++; if (lsu_arready !== 1'b0 || m_arvalid !== 1'b0) begin miscompares++; $display("FAIL mid_idle: got rdy %b v %b want 0/0", lsu_arready, m_arvalid); end
    tick();
    vectors++; if (lsu_arready !== 1'b1 || m_arid !== 4'd1) begin miscompares++; $display("FAIL mid_grant: got rdy %b id %0d want 1/1", lsu_arready, m_arid); end
  endtask

  task automatic test_reset_midtxn;
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0300; ifu_arlen = 8'd2;
    tick();
    m_arready = 1;
    tick();
    ifu_arvalid = 0; m_arready = 0;
    ifu_rready = 1; m_rvalid = 1; m_rlast = 0;
    #1;
    vectors++; if (ifu_rvalid !== 1'b1 || m_rready !== 1'b1) begin miscompares++; $display("FAIL arst_pre: got %b%b want 11", ifu_rvalid, m_rready); end
    reset = 1'b1;
    #1;
    vectors++; if (ifu_rvalid !== 1'b0 || m_rready !== 1'b0) begin miscompares++; $display("FAIL arst_async: got %b%b want 00", ifu_rvalid, m_rready); end
    m_rvalid = 0;
    ifu_arvalid = 1; lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL arst_idle: got %b want 0", m_arvalid); end
    tick();
    vectors++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0 || m_arlen !== 8'd2) begin miscompares++; $display("FAIL arst_regrant: got v%b id%0d len%0d want 1/0/2", m_arvalid, m_arid, m_arlen); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_ifu_burst();
    test_tie();
    test_write();
    test_write_vs_read();
    test_midburst();
    test_reset_midtxn();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
